// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register offsets, STATUS bit positions, FSM states and level helper for uart_rx
package uart_rx_pkg;

    localparam logic [2:0] UART_RX_DATA   = 3'd0;
    localparam logic [2:0] UART_RX_STATUS = 3'd1;
    localparam logic [2:0] UART_RX_LEVEL  = 3'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    function automatic logic [7:0] sat_level(input logic [15:0] lvl);
        return (lvl > 16'd255) ? 8'hFF : lvl[7:0];
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push on full only lands when a pop frees a slot in the same cycle
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign dout  = mem[rptr];

    // a pop on empty is a no-op; a push on full needs the same-cycle pop to make room
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with receive FIFO behind the peripheral slave bus
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] addr,
    input  logic       ren,
    output logic [7:0] rdata,
    output logic       rd_valid,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rx,
    output logic       rx_avail
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic          rx_m, rx_s;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          armed, armed_n;
    logic          push, ferr_set;

    logic [2:0]    sel;
    logic          pop, wr_st, ovr_set;
    logic          ovr, ferr;
    logic [7:0]    dout, status, rd_mux;
    logic          full, empty;
    logic [LW-1:0] level;
    logic          unused_bits;

    assign sel         = addr[2:0];
    assign pop         = ren && sel == UART_RX_DATA;
    assign wr_st       = wen && sel == UART_RX_STATUS;
    assign ovr_set     = push && full && !pop;
    assign rx_avail    = !empty;
    assign unused_bits = ^{addr[4:3], wdata[7:4], wdata[1:0]};

    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // two-flop synchroniser, idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // receive FSM and baud counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            armed   <= armed_n;
        end
    end

    // frame sequencing: half-bit wait to mid start bit, then whole bits; disarm after stop so a break reports once
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        armed_n   = armed;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                armed_n = armed | rx_s;
                if (armed && !rx_s) begin
                    cnt_n   = HALF;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n     = FULL;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    cnt_n     = FULL;
                    bit_idx_n = bit_idx + 1'b1;
                    state_n   = (bit_idx == 3'd7) ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    push     = rx_s;
                    ferr_set = !rx_s;
                    armed_n  = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // read-data mux; an empty DATA read returns zero rather than the stale head
    always_comb begin
        status               = '0;
        status[ST_NOT_EMPTY] = !empty;
        status[ST_FULL]      = full;
        status[ST_OVERRUN]   = ovr;
        status[ST_FRAME_ERR] = ferr;
        rd_mux = (sel == UART_RX_DATA)   ? (empty ? 8'h00 : dout) :
                 (sel == UART_RX_STATUS) ? status :
                 (sel == UART_RX_LEVEL)  ? sat_level(16'(level)) : 8'h00;
    end

    // bus response and sticky flags; a hardware set beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rd_valid <= ren;
            if (ren) rdata <= rd_mux;
            ovr  <= ovr_set | (ovr & !(wr_st & wdata[ST_OVERRUN]));
            ferr <= ferr_set | (ferr & !(wr_st & wdata[ST_FRAME_ERR]));
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] addr = '0;
    logic       ren = 1'b0;
    logic       wen = 1'b0;
    logic [7:0] wdata = '0;
    logic       rx = 1'b1;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       rx_avail;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] d;

    uart_rx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .ren      (ren),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .wen      (wen),
        .wdata    (wdata),
        .rx       (rx),
        .rx_avail (rx_avail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(stop);
        if (!stop) m_ferr = 1'b1;
        else if (sb.size() < 16) sb.push_back(v);
        else m_ovr = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        addr = {2'b00, a};
        ren = 1'b1;
        tick(1);
        ren = 1'b0;
        chk("rd_valid_pulse", {7'b0, rd_valid}, 8'h01);
        v = rdata;
        tick(1);
        chk("rd_valid_drop", {7'b0, rd_valid}, 8'h00);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] v);
        addr = {2'b00, a};
        wdata = v;
        wen = 1'b1;
        tick(1);
        wen = 1'b0;
        if (a == 3'd1 && v[2]) m_ovr = 1'b0;
        if (a == 3'd1 && v[3]) m_ferr = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        logic [7:0] v;
        rd(3'd1, v);
        chk(tag, v, {4'b0, m_ferr, m_ovr, sb.size() == 16, sb.size() != 0});
    endtask

    task automatic chk_level(input string tag);
        logic [7:0] v;
        rd(3'd2, v);
        chk(tag, v, 8'(sb.size()));
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] v, e;
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        rd(3'd0, v);
        chk(tag, v, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rd_valid", {7'b0, rd_valid}, 8'h00);
        chk("rst_avail", {7'b0, rx_avail}, 8'h00);
        rstn = 1'b1;
        tick(5);
        chk_status("rst_status");
        chk_level("rst_level");

        send_frame(8'hA5, 1'b1);
        for (int i = 0; i < 50 && !rx_avail; i++) tick(1);
        chk("t1_avail", {7'b0, rx_avail}, 8'h01);
        chk_status("t1_status");
        chk_level("t1_level");
        chk_data("t1_data");
        chk_status("t1_status_after");
        chk("t1_avail_after", {7'b0, rx_avail}, 8'h00);

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        tick(4);
        chk_level("t2_level");
        chk_status("t2_status");
        for (int i = 0; i < 16; i++) chk_data("t2_data");
        chk_data("t2_data_empty");
        wr(3'd1, 8'h04);
        chk_status("t2_status_w1c");

        send_frame(8'h55, 1'b0);
        tick(100);
        chk_status("t3_status_ferr");
        chk_level("t3_level");
        wr(3'd1, 8'h08);
        tick(100);
        chk_status("t3_status_break_once");
        rx = 1'b1;
        tick(20);
        chk_status("t3_status_idle");
        chk_level("t3_level_idle");

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        chk_level("t4_level");
        chk_status("t4_status");
        send_frame(8'h3C, 1'b1);
        tick(4);
        chk_data("t4_data");

        chk_data("t5_empty_data");
        chk_level("t5_level");
        rd(3'd5, d);
        chk("t5_off5", d, 8'h00);

        send_frame(8'h99, 1'b1);
        tick(4);
        chk_status("t6_pre_status");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        tick(8);
        rstn = 1'b0;
        rx = 1'b1;
        tick(2);
        rstn = 1'b1;
        sb.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        chk("t6_rst_rdata", rdata, 8'h00);
        chk("t6_rst_avail", {7'b0, rx_avail}, 8'h00);
        tick(20);
        chk_level("t6_level_empty");
        send_frame(8'hC3, 1'b1);
        tick(4);
        chk_level("t6_level");
        chk_data("t6_data");
        chk_data("t6_data_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
